// File: rtl/cpu_boot_loader.sv
// Minimal TL-UL / multibit type packages followed by the cold-boot sequencer that streams
// instruction words into the cluster's instruction memory and then releases the core.
package prim_mubi_pkg;
  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;
endpackage

package ibex_pkg;
  typedef logic [3:0] ibex_mubi_t;
  parameter ibex_mubi_t IbexMuBiOn  = 4'b0101;
  parameter ibex_mubi_t IbexMuBiOff = 4'b1010;
endpackage

package tlul_pkg;
  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0]            rsvd;
    prim_mubi_pkg::mubi4_t instr_type;
    logic [6:0]            cmd_intg;
    logic [6:0]            data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: prim_mubi_pkg::MuBi4False,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic       a_valid;
    tl_a_op_e   a_opcode;
    logic [2:0] a_param;
    logic [1:0] a_size;
    logic [7:0] a_source;
    logic [31:0] a_address;
    logic [3:0] a_mask;
    logic [31:0] a_data;
    tl_a_user_t a_user;
    logic       d_ready;
  } tl_h2d_t;

  parameter tl_h2d_t TL_H2D_DEFAULT = '{
    a_valid:   1'b0,
    a_opcode:  PutFullData,
    a_param:   3'h0,
    a_size:    2'h0,
    a_source:  8'h0,
    a_address: 32'h0,
    a_mask:    4'h0,
    a_data:    32'h0,
    a_user:    TL_A_USER_DEFAULT,
    d_ready:   1'b1
  };

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module cpu_boot_loader #(
  parameter logic [31:0] BaseAddr = 32'h0000_0080,
  parameter int unsigned MaxWords = 32,
  parameter logic [31:0] EndWord  = 32'h0000_0fff,
  parameter int unsigned CntW     = $clog2(MaxWords + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  halt_i,
  input  logic                  wr_valid_i,
  input  logic [31:0]           wr_data_i,
  output logic                  wr_ready_o,
  output tlul_pkg::tl_h2d_t     tl_o,
  input  tlul_pkg::tl_d2h_t     tl_i,
  output ibex_pkg::ibex_mubi_t  fetch_enable_o,
  output prim_mubi_pkg::mubi4_t en_ifetch_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CntW-1:0]       word_cnt_o,
  output logic [2:0]            state_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StReq  = 3'd2;
  localparam logic [2:0] StRsp  = 3'd3;
  localparam logic [2:0] StRun  = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [31:0]     r_word;
  logic            r_is_end;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;
  logic            r_core_en;
  logic            w_wr_hs;
  logic            w_rsp_ok;
  logic            w_restart;
  logic [31:0]     w_addr;
  logic            w_unused_tl;

  assign w_wr_hs   = (r_state == StLoad) && wr_valid_i;
  assign w_rsp_ok  = (r_state == StRsp) && tl_i.d_valid && !tl_i.d_error;
  assign w_restart = ((r_state == StIdle) || (r_state == StErr)) && start_i;
  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_addr    = BaseAddr + (32'(r_cnt) << 2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (start_i) w_state_nxt = StLoad;
      StLoad: if (wr_valid_i) w_state_nxt = StReq;
      StReq:  if (tl_i.a_ready) w_state_nxt = StRsp;
      StRsp: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error)                   w_state_nxt = StErr;
          else if (r_is_end)                  w_state_nxt = StRun;
          else if (w_cnt_inc == CntW'(MaxWords)) w_state_nxt = StErr;
          else                                w_state_nxt = StLoad;
        end
      end
      StRun:  if (halt_i) w_state_nxt = StIdle;
      StErr:  if (start_i) w_state_nxt = StLoad;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_word    <= 32'h0;
      r_is_end  <= 1'b0;
      r_cnt     <= '0;
      r_core_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      // Enables follow RUN by one cycle and drop together with the halt.
      r_core_en <= (r_state == StRun) && !halt_i;
      if (w_wr_hs) begin
        r_word   <= wr_data_i;
        r_is_end <= (wr_data_i == EndWord);
      end
      if (w_restart)     r_cnt <= '0;
      else if (w_rsp_ok) r_cnt <= w_cnt_inc;
    end
  end

  always_comb begin
    tl_o         = tlul_pkg::TL_H2D_DEFAULT;
    tl_o.d_ready = 1'b1;
    if (r_state == StReq) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = tlul_pkg::PutFullData;
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = 8'h0;
      tl_o.a_address = w_addr;
      tl_o.a_mask    = 4'hf;
      tl_o.a_data    = r_word;
      tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    end
  end

  assign wr_ready_o     = (r_state == StLoad);
  assign busy_o         = (r_state == StLoad) || (r_state == StReq) || (r_state == StRsp);
  assign done_o         = (r_state == StRun);
  assign err_o          = (r_state == StErr);
  assign word_cnt_o     = r_cnt;
  assign state_o        = r_state;
  assign fetch_enable_o = r_core_en ? ibex_pkg::IbexMuBiOn : ibex_pkg::IbexMuBiOff;
  assign en_ifetch_o    = r_core_en ? prim_mubi_pkg::MuBi4True : prim_mubi_pkg::MuBi4False;

  assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_data, tl_i.d_user};

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: random word streams against a TL-UL memory responder,
// with expected writes and final outcome derived from the load rules.
module tb_cpu_boot_loader;
  import tlul_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0080;
  localparam int          MAXW = 4;
  localparam logic [31:0] ENDW = 32'h0000_0fff;
  localparam int          CW   = $clog2(MAXW + 1);

  logic                  clk_i;
  logic                  rst_ni;
  logic                  start_i;
  logic                  halt_i;
  logic                  wr_valid_i;
  logic [31:0]           wr_data_i;
  logic                  wr_ready_o;
  tl_h2d_t               tl_o;
  tl_d2h_t               tl_i;
  ibex_pkg::ibex_mubi_t  fetch_enable_o;
  prim_mubi_pkg::mubi4_t en_ifetch_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [CW-1:0]         word_cnt_o;
  logic [2:0]            state_o;

  cpu_boot_loader #(
    .BaseAddr(BASE),
    .MaxWords(MAXW),
    .EndWord (ENDW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .halt_i        (halt_i),
    .wr_valid_i    (wr_valid_i),
    .wr_data_i     (wr_data_i),
    .wr_ready_o    (wr_ready_o),
    .tl_o          (tl_o),
    .tl_i          (tl_i),
    .fetch_enable_o(fetch_enable_o),
    .en_ifetch_o   (en_ifetch_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .word_cnt_o    (word_cnt_o),
    .state_o       (state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[$];

  int   load_id          = 0;
  int   dev_err_at       = -1;
  int   dev_stall_at     = -1;
  int   dev_stall_len    = 0;
  logic dev_hold         = 1'b0;
  logic dev_force_dvalid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // TL-UL memory responder with random a_ready / d_valid latency
  initial begin : device
    int          stall;
    int          delay;
    int          rsp_idx;
    int          req_idx;
    int          seen_load;
    logic        in_req;
    logic        pending;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic [63:0] w;
    tl_i = '0;
    stall = 0; delay = 0; rsp_idx = 0; req_idx = 0; seen_load = 0;
    in_req = 1'b0; pending = 1'b0;
    forever begin
      @(negedge clk_i);
      tl_i.a_ready = 1'b0;
      tl_i.d_valid = 1'b0;
      tl_i.d_error = 1'b0;
      if (!rst_ni || dev_hold) begin
        in_req = 1'b0;
        pending = 1'b0;
        tl_i.d_valid = dev_force_dvalid;
        continue;
      end
      if (seen_load != load_id) begin
        seen_load = load_id;
        rsp_idx = 0;
        req_idx = 0;
      end
      if (pending) begin
        if (delay == 0) begin
          tl_i.d_valid  = 1'b1;
          tl_i.d_opcode = AccessAck;
          tl_i.d_error  = (rsp_idx == dev_err_at);
          rsp_idx++;
          pending = 1'b0;
        end else begin
          delay--;
        end
      end else if (tl_o.a_valid) begin
        if (!in_req) begin
          in_req   = 1'b1;
          cap_addr = tl_o.a_address;
          cap_data = tl_o.a_data;
          stall    = (req_idx == dev_stall_at) ? dev_stall_len : $urandom_range(0, 2);
        end else begin
          check("req_addr_stable", tl_o.a_address, cap_addr);
          check("req_data_stable", tl_o.a_data, cap_data);
          check("wr_ready_in_req", wr_ready_o, 1'b0);
        end
        if (stall > 0) begin
          stall--;
        end else begin
          tl_i.a_ready = 1'b1;
          in_req  = 1'b0;
          pending = 1'b1;
          delay   = $urandom_range(0, 2);
          req_idx++;
          check("put_fields",
                {tl_o.a_opcode, tl_o.a_param, tl_o.a_size, tl_o.a_source, tl_o.a_mask, tl_o.d_ready},
                {3'd0, 3'd0, 2'd2, 8'd0, 4'hf, 1'b1});
          if (exp_q.size() == 0) begin
            check("unexpected_write", tl_o.a_address, 64'hdead);
          end else begin
            w = exp_q.pop_front();
            check("write_addr_data", {tl_o.a_address, tl_o.a_data}, w);
          end
        end
      end else if (in_req) begin
        check("req_dropped", 1'b0, 1'b1);
        in_req = 1'b0;
      end
    end
  end

  // driver: one full load of `words`, model computes writes and outcome
  task automatic run_load(input int err_at, input int stall_at, input int stall_len,
                          output int n_out, output bit run_out);
    int feed;
    int budget;
    n_out = 0; run_out = 1'b0; feed = 0;
    exp_q.delete();
    for (int k = 0; k < words.size(); k++) begin
      exp_q.push_back({BASE + 32'(4 * k), words[k]});
      feed++;
      if (k == err_at) break;
      n_out++;
      if (words[k] == ENDW) begin
        run_out = 1'b1;
        break;
      end
      if (n_out == MAXW) break;
    end
    dev_err_at = err_at; dev_stall_at = stall_at; dev_stall_len = stall_len;
    load_id++;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 0; k < feed; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      wr_valid_i = 1'b1;
      wr_data_i  = words[k];
      budget = 0;
      while (!wr_ready_o && budget < 200) begin
        @(negedge clk_i);
        budget++;
      end
      if (budget >= 200) check("wr_accept_timeout", 1'b0, 1'b1);
      @(negedge clk_i);
      wr_valid_i = 1'b0;
      wr_data_i  = $urandom;
    end
    budget = 0;
    while (!done_o && !err_o && budget < 200) begin
      @(negedge clk_i);
      budget++;
    end
    check("outcome_in_time", budget < 200, 1'b1);
    check("done", done_o, run_out);
    check("err", err_o, !run_out);
    check("busy_end", busy_o, 1'b0);
    check("word_cnt", word_cnt_o, n_out);
    repeat (2) @(negedge clk_i);
    check("fetch_enable", fetch_enable_o, run_out ? ibex_pkg::IbexMuBiOn : ibex_pkg::IbexMuBiOff);
    check("en_ifetch", en_ifetch_o, run_out ? prim_mubi_pkg::MuBi4True : prim_mubi_pkg::MuBi4False);
    repeat (4) @(negedge clk_i);
    check("writes_pending", exp_q.size(), 0);
    check("no_req_after", tl_o.a_valid, 1'b0);
  endtask

  task automatic halt_core(input bit with_start, input int n);
    @(negedge clk_i); halt_i = 1'b1; start_i = with_start;
    @(negedge clk_i); halt_i = 1'b0; start_i = 1'b0;
    check("halt_flags", {busy_o, done_o, err_o}, 3'b000);
    @(negedge clk_i);
    check("halt_fetch_off", fetch_enable_o, ibex_pkg::IbexMuBiOff);
    check("halt_ifetch_off", en_ifetch_o, prim_mubi_pkg::MuBi4False);
    check("halt_no_load", {busy_o, wr_ready_o}, 2'b00);
    check("halt_cnt_kept", word_cnt_o, n);
  endtask

  task automatic rand_words();
    int len;
    bit term;
    logic [31:0] w;
    words.delete();
    term = $urandom_range(0, 1);
    len  = term ? $urandom_range(1, MAXW) : MAXW;
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      if (w == ENDW) w = w ^ 32'h1;
      words.push_back(w);
    end
    if (term) words[len-1] = ENDW;
  endtask

  initial begin : watchdog
    #500000;
    check("watchdog", 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : main
    int n;
    bit r;
    int budget;
    rst_ni = 1'b0; start_i = 1'b0; halt_i = 1'b0;
    wr_valid_i = 1'b0; wr_data_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check("rst_flags", {wr_ready_o, busy_o, done_o, err_o}, 4'b0000);
    check("rst_cnt", word_cnt_o, 0);
    check("rst_fetch", fetch_enable_o, ibex_pkg::IbexMuBiOff);
    check("rst_ifetch", en_ifetch_o, prim_mubi_pkg::MuBi4False);
    check("rst_tl", {tl_o.a_valid, tl_o.d_ready, tl_o.a_address}, {1'b0, 1'b1, 32'h0});
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // directed program, then start/wr_valid ignored in RUN, halt wins over start
    words = '{32'h0000_0513, 32'h00a0_0593, 32'h0000_0fff};
    run_load(-1, -1, 0, n, r);
    @(negedge clk_i); start_i = 1'b1; wr_valid_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    check("run_ignores_start", {done_o, busy_o, wr_ready_o}, 3'b100);
    @(negedge clk_i); wr_valid_i = 1'b0;
    check("run_ignores_wr", {done_o, word_cnt_o}, {1'b1, CW'(3)});
    halt_core(1'b1, 3);

    // second word stalled 5 cycles on a_ready
    words = '{32'h1234_5678, 32'h8765_4321, 32'h0000_0fff};
    run_load(-1, 1, 5, n, r);
    halt_core(1'b0, n);

    // error on second response, then reload from base
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0fff};
    run_load(1, -1, 0, n, r);
    @(negedge clk_i); halt_i = 1'b1;
    @(negedge clk_i); halt_i = 1'b0;
    check("err_ignores_halt", err_o, 1'b1);
    words = '{32'h0000_0513, 32'h00a0_0593, 32'h0000_0fff};
    run_load(-1, -1, 0, n, r);
    halt_core(1'b0, n);

    // missing terminator
    words = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    run_load(-1, -1, 0, n, r);

    // randomized loads
    for (int it = 0; it < 25; it++) begin
      rand_words();
      run_load(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, words.size() - 1)) : -1,
               -1, 0, n, r);
      if (r) halt_core($urandom_range(0, 1), n);
    end

    // reset while a request is outstanding
    if (err_o) begin
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
    end else begin
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
    end
    exp_q.delete();
    exp_q.push_back({BASE, 32'hcafe_f00d});
    dev_err_at = -1; dev_stall_at = 0; dev_stall_len = 50;
    load_id++;
    wr_valid_i = 1'b1; wr_data_i = 32'hcafe_f00d;
    budget = 0;
    while (!tl_o.a_valid && budget < 50) begin
      @(negedge clk_i);
      budget++;
    end
    wr_valid_i = 1'b0;
    check("rst_pre_avalid", tl_o.a_valid, 1'b1);
    dev_hold = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_avalid", tl_o.a_valid, 1'b0);
    check("rst_mid_flags", {wr_ready_o, busy_o, done_o, err_o, word_cnt_o}, 0);
    check("rst_mid_enables", {fetch_enable_o, en_ifetch_o},
          {ibex_pkg::IbexMuBiOff, prim_mubi_pkg::MuBi4False});
    @(negedge clk_i); rst_ni = 1'b1;
    dev_force_dvalid = 1'b1;
    repeat (2) @(negedge clk_i);
    dev_force_dvalid = 1'b0;
    @(negedge clk_i);
    check("late_dvalid_ignored", {busy_o, done_o, err_o, tl_o.a_valid, word_cnt_o}, 0);
    dev_hold = 1'b0;
    exp_q.delete();

    // recovery after reset
    words = '{32'h0000_0513, 32'h0000_0fff};
    run_load(-1, -1, 0, n, r);
    halt_core(1'b0, n);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
